regfile_bypass_multi: RTL

Parametrised successor to the 8x16b bypassed register file: an N-entry, W-bit register file with two combinational read ports, two write ports with same-cycle write-through bypass from both, and a per-register busy scoreboard. It sits in the decode stage of the pipelined core. It supplies operands, and flags operands whose producer has not yet written back, so hazard logic can stall. A sticky error flags same-register write collisions.

---
 rtl/regfile_bypass_multi.sv | 127 ++++++++++++
 1 files changed

// File: rtl/regfile_bypass_multi.sv
// Decode-stage register file: two combinational read ports with write-through bypass,
// two write ports (port 1 wins), a per-register busy scoreboard and a sticky collision flag.
module regfile_bypass_multi #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int SEL_W    = $clog2(NUM_REGS),
   parameter int ZERO_REG = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [SEL_W-1:0]  read1RegSel,
   input  logic [SEL_W-1:0]  read2RegSel,
   output logic [DATA_W-1:0] read1Data,
   output logic [DATA_W-1:0] read2Data,
   output logic              read1Busy,
   output logic              read2Busy,
   input  logic              wr0En,
   input  logic [SEL_W-1:0]  wr0Sel,
   input  logic [DATA_W-1:0] wr0Data,
   input  logic              wr1En,
   input  logic [SEL_W-1:0]  wr1Sel,
   input  logic [DATA_W-1:0] wr1Data,
   input  logic              rsvEn,
   input  logic [SEL_W-1:0]  rsvSel,
   output logic              err
);

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic                err_q;
   logic                err_d;

   logic wr0_eff;
   logic wr1_eff;
   logic rsv_eff;
   logic rd1_hit0;
   logic rd1_hit1;
   logic rd2_hit0;
   logic rd2_hit1;
   logic rd1_zero;
   logic rd2_zero;

   // Writes and reserves aimed at a hardwired zero register are dropped entirely.
   always_comb begin
      wr0_eff  = wr0En && !((ZERO_REG != 0) && (wr0Sel == '0));
      wr1_eff  = wr1En && !((ZERO_REG != 0) && (wr1Sel == '0));
      rsv_eff  = rsvEn && !((ZERO_REG != 0) && (rsvSel == '0));
      rd1_hit0 = wr0_eff && (wr0Sel == read1RegSel);
      rd1_hit1 = wr1_eff && (wr1Sel == read1RegSel);
      rd2_hit0 = wr0_eff && (wr0Sel == read2RegSel);
      rd2_hit1 = wr1_eff && (wr1Sel == read2RegSel);
      rd1_zero = (ZERO_REG != 0) && (read1RegSel == '0);
      rd2_zero = (ZERO_REG != 0) && (read2RegSel == '0);
   end

   // Order matters: port 1 overrides port 0, and a reserve overrides the busy clear.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      err_d  = err_q;
      if (wr0_eff) begin
         regs_d[wr0Sel] = wr0Data;
         busy_d[wr0Sel] = 1'b0;
      end
      if (wr1_eff) begin
         regs_d[wr1Sel] = wr1Data;
         busy_d[wr1Sel] = 1'b0;
      end
      if (rsv_eff) begin
         busy_d[rsvSel] = 1'b1;
      end
      if (wr0_eff && wr1_eff && (wr0Sel == wr1Sel)) begin
         err_d = 1'b1;
      end
      if (ZERO_REG != 0) begin
         regs_d[0] = '0;
         busy_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
         err_q  <= 1'b0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   always_comb begin
      read1Data = regs_q[read1RegSel];
      if (!rst || rd1_zero) begin
         read1Data = '0;
      end else if (rd1_hit1) begin
         read1Data = wr1Data;
      end else if (rd1_hit0) begin
         read1Data = wr0Data;
      end
   end

   always_comb begin
      read2Data = regs_q[read2RegSel];
      if (!rst || rd2_zero) begin
         read2Data = '0;
      end else if (rd2_hit1) begin
         read2Data = wr1Data;
      end else if (rd2_hit0) begin
         read2Data = wr0Data;
      end
   end

   // A write landing this cycle satisfies the dependency through the bypass.
   always_comb begin
      read1Busy = rst && busy_q[read1RegSel] && !(rd1_hit0 || rd1_hit1);
      read2Busy = rst && busy_q[read2RegSel] && !(rd2_hit0 || rd2_hit1);
   end

   assign err = err_q;

endmodule
